// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-controller encodings and the operand-forwarding rule.
package pipe_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  // Memory stage wins over writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             wr_m,
    input logic [REG_W-1:0] rd_m,
    input logic             wr_w,
    input logic [REG_W-1:0] rd_w,
    input logic [REG_W-1:0] rs
  );
    return (wr_m && rd_m != '0 && rd_m == rs) ? FWD_M :
           (wr_w && rd_w != '0 && rd_w == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_en && !(&r_count)) r_count <= r_count + 1'b1;
  end
  assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage stall/flush/forward control with memory-wait timeout
// and a saturating stall-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemFault,
  output logic [CNT_W-1:0] StallCount
);
  localparam logic [7:0] WMAX = 8'(WAIT_MAX);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_wcnt, w_wcnt_nxt;
  logic       r_fault;
  logic       w_mem_wait, w_lw_stall, w_hold;
  assign w_mem_wait = MemReqM && !MemReadyM;
  assign w_lw_stall = ResultSrcE0 && RegWriteE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign ForwardAE  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_wcnt  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_fault <= r_fault || w_state_nxt == HALT;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      RUN: if (w_mem_wait) begin
        w_state_nxt = WAIT;
        w_wcnt_nxt  = 8'd1;
      end
      WAIT: if (MemReadyM) begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = '0;
      end else if (w_mem_wait) begin
        if (r_wcnt >= WMAX) w_state_nxt = HALT;
        else w_wcnt_nxt = r_wcnt + 8'd1;
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = RUN;
    endcase
  end
  // A held memory access (or a halt) freezes F..M and suppresses branch and
  // load-use handling; a taken branch then beats a load-use stall.
  assign w_hold   = r_state == HALT || w_mem_wait;
  assign StallF   = w_hold || (!PCSrcE && w_lw_stall);
  assign StallD   = StallF;
  assign StallE   = w_hold;
  assign StallM   = w_hold;
  assign FlushW   = w_hold;
  assign FlushD   = !w_hold && PCSrcE;
  assign FlushE   = !w_hold && (PCSrcE || w_lw_stall);
  assign MemFault = r_fault;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_en   (StallF),
    .o_count(StallCount)
  );
endmodule
